game_timer: RTL and testbench

- Countdown game timer that consumes the timer setting produced by the main game FSM and returns `timer_stop` to it.
- Loads `timer_seconds` on a start pulse and decrements once per second using an internal prescaler.
- Freezes when the game is won or lost, and clears on retry.
- Drives binary and BCD seconds values for the on-screen counter display.

---
 rtl/game_timer.sv | 119 +++++++++++
 tb/tb_game_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// game_timer: countdown/count-up game timer with prescaler and BCD seconds display
module game_timer #(
  parameter int CLK_DIV = 40_000_000,
  parameter int MAX_SECONDS = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] timer_seconds,
  input  logic       freeze,
  input  logic       clear,
  output logic       timer_stop,
  output logic       running,
  output logic       tick,
  output logic [9:0] seconds_val,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
  localparam logic [9:0] MAX = 10'(MAX_SECONDS);

  typedef enum logic [2:0] {IDLE, RUN_DOWN, RUN_UP, FROZEN, EXPIRED} state_t;

  state_t state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [9:0] sec_n, load;
  logic [3:0] hund_n, tens_n, ones_n;
  logic [3:0] dec_h, dec_t, dec_o, inc_h, inc_t, inc_o;
  logic [11:0] load_bcd;
  logic tick_n, wrap;

  function automatic logic [11:0] to_bcd(input logic [9:0] b);
    logic [21:0] s;
    s = {12'b0, b};
    for (int i = 0; i < 10; i++) begin
      if (s[13:10] >= 4'd5) s[13:10] = s[13:10] + 4'd3;
      if (s[17:14] >= 4'd5) s[17:14] = s[17:14] + 4'd3;
      if (s[21:18] >= 4'd5) s[21:18] = s[21:18] + 4'd3;
      s = s << 1;
    end
    return s[21:10];
  endfunction

  assign load = timer_seconds > MAX ? MAX : timer_seconds;
  assign load_bcd = to_bcd(load);
  assign wrap = presc == LAST;

  assign dec_o = bcd_ones == 4'd0 ? 4'd9 : bcd_ones - 4'd1;
  assign dec_t = bcd_ones != 4'd0 ? bcd_tens : (bcd_tens == 4'd0 ? 4'd9 : bcd_tens - 4'd1);
  assign dec_h = (bcd_ones == 4'd0 && bcd_tens == 4'd0) ? bcd_hund - 4'd1 : bcd_hund;
  assign inc_o = bcd_ones == 4'd9 ? 4'd0 : bcd_ones + 4'd1;
  assign inc_t = bcd_ones != 4'd9 ? bcd_tens : (bcd_tens == 4'd9 ? 4'd0 : bcd_tens + 4'd1);
  assign inc_h = (bcd_ones == 4'd9 && bcd_tens == 4'd9) ? bcd_hund + 4'd1 : bcd_hund;

  assign timer_stop = state == EXPIRED;
  assign running = state == RUN_DOWN || state == RUN_UP;

  // next state, prescaler and seconds/BCD values; clear beats start beats freeze beats tick
  always_comb begin
    state_n = state;
    presc_n = presc;
    sec_n = seconds_val;
    hund_n = bcd_hund;
    tens_n = bcd_tens;
    ones_n = bcd_ones;
    tick_n = 1'b0;
    if (clear) begin
      state_n = IDLE;
      presc_n = '0;
      sec_n = '0;
      {hund_n, tens_n, ones_n} = '0;
    end else if (start) begin
      state_n = timer_seconds == 10'd0 ? RUN_UP : RUN_DOWN;
      presc_n = '0;
      sec_n = load;
      {hund_n, tens_n, ones_n} = load_bcd;
    end else if (running && freeze) begin
      state_n = FROZEN;
    end else if (state == RUN_DOWN) begin
      presc_n = wrap ? '0 : presc + 1'b1;
      if (wrap) begin
        sec_n = seconds_val - 10'd1;
        {hund_n, tens_n, ones_n} = {dec_h, dec_t, dec_o};
        tick_n = 1'b1;
        state_n = seconds_val == 10'd1 ? EXPIRED : RUN_DOWN;
      end
    end else if (state == RUN_UP) begin
      presc_n = wrap ? '0 : presc + 1'b1;
      if (wrap && seconds_val < MAX) begin
        sec_n = seconds_val + 10'd1;
        {hund_n, tens_n, ones_n} = {inc_h, inc_t, inc_o};
        tick_n = 1'b1;
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      seconds_val <= '0;
      bcd_hund <= '0;
      bcd_tens <= '0;
      bcd_ones <= '0;
      tick <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      seconds_val <= sec_n;
      bcd_hund <= hund_n;
      bcd_tens <= tens_n;
      bcd_ones <= ones_n;
      tick <= tick_n;
    end
  end
endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: cycle-stamped scoreboard bench for game_timer
module tb_game_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [9:0] timer_seconds = '0;
  logic freeze = 1'b0;
  logic clear = 1'b0;
  logic timer_stop, running, tick;
  logic [9:0] seconds_val;
  logic [3:0] bcd_hund, bcd_tens, bcd_ones;

  game_timer #(.CLK_DIV(4), .MAX_SECONDS(999)) dut (
    .clk(clk), .rst(rst), .start(start), .timer_seconds(timer_seconds),
    .freeze(freeze), .clear(clear), .timer_stop(timer_stop), .running(running),
    .tick(tick), .seconds_val(seconds_val), .bcd_hund(bcd_hund),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    string name;
    logic [9:0] sec;
    logic [11:0] bcd;
    logic stop;
    logic run;
    logic tk;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc++;

  // monitor: at each falling edge pop every expectation stamped for this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (e.cyc != cyc || seconds_val != e.sec || {bcd_hund, bcd_tens, bcd_ones} != e.bcd ||
          timer_stop != e.stop || running != e.run || tick != e.tk) begin
        n_bad++;
        $display("FAIL %s @cyc %0d (due %0d): got sec=%0d bcd=%h stop=%b run=%b tick=%b, want sec=%0d bcd=%h stop=%b run=%b tick=%b",
                 e.name, cyc, e.cyc, seconds_val, {bcd_hund, bcd_tens, bcd_ones}, timer_stop, running, tick,
                 e.sec, e.bcd, e.stop, e.run, e.tk);
      end
    end
  end

  function automatic void expect_at(int c, string n, int sec, logic [11:0] bcd, bit st, bit rn, bit tk);
    exp_t e;
    e.cyc = c; e.name = n; e.sec = 10'(sec); e.bcd = bcd; e.stop = st; e.run = rn; e.tk = tk;
    q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(int c);
    while (cyc < c) step();
  endtask

  task automatic pulse(bit c, bit s, logic [9:0] ts, output int at);
    clear = c; start = s; timer_seconds = ts;
    step();
    at = cyc;
    clear = 1'b0; start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    repeat (10) step();
    rst = 1'b0;
    expect_at(cyc, "reset", 0, 12'h000, 0, 0, 0);
    step();
    // countdown from 3 to expiry
    pulse(0, 1, 10'd3, s);
    expect_at(s, "load3", 3, 12'h003, 0, 1, 0);
    expect_at(s + 3, "pre_tick", 3, 12'h003, 0, 1, 0);
    expect_at(s + 4, "tick_2", 2, 12'h002, 0, 1, 1);
    expect_at(s + 5, "tick_pulse_1cyc", 2, 12'h002, 0, 1, 0);
    expect_at(s + 8, "tick_1", 1, 12'h001, 0, 1, 1);
    expect_at(s + 12, "expire", 0, 12'h000, 1, 0, 1);
    expect_at(s + 13, "expired_hold", 0, 12'h000, 1, 0, 0);
    run_to(s + 14);
    // tens and hundreds borrow
    pulse(0, 1, 10'd10, s);
    expect_at(s, "load10", 10, 12'h010, 0, 1, 0);
    expect_at(s + 4, "borrow_tens", 9, 12'h009, 0, 1, 1);
    run_to(s + 4);
    pulse(0, 1, 10'd100, s);
    expect_at(s, "load100", 100, 12'h100, 0, 1, 0);
    expect_at(s + 4, "borrow_hund", 99, 12'h099, 0, 1, 1);
    run_to(s + 4);
    // freeze after one tick, then clear
    pulse(0, 1, 10'd5, s);
    expect_at(s + 4, "pre_freeze", 4, 12'h004, 0, 1, 1);
    expect_at(s + 5, "frozen", 4, 12'h004, 0, 0, 0);
    expect_at(s + 8, "frozen_wrap", 4, 12'h004, 0, 0, 0);
    expect_at(s + 25, "frozen_20", 4, 12'h004, 0, 0, 0);
    run_to(s + 4);
    freeze = 1'b1;
    run_to(s + 25);
    pulse(1, 0, 10'd0, s);
    expect_at(s, "clear_frozen", 0, 12'h000, 0, 0, 0);
    expect_at(s + 5, "idle_freeze_ignored", 0, 12'h000, 0, 0, 0);
    run_to(s + 5);
    freeze = 1'b0;
    // freeze coinciding with a wrap wins
    pulse(0, 1, 10'd5, s);
    expect_at(s, "load5", 5, 12'h005, 0, 1, 0);
    expect_at(s + 4, "freeze_wins", 5, 12'h005, 0, 0, 0);
    expect_at(s + 8, "freeze_hold", 5, 12'h005, 0, 0, 0);
    run_to(s + 3);
    freeze = 1'b1;
    run_to(s + 8);
    freeze = 1'b0;
    pulse(1, 0, 10'd0, s);
    expect_at(s, "clear2", 0, 12'h000, 0, 0, 0);
    // untimed count-up to saturation
    pulse(0, 1, 10'd0, s);
    expect_at(s, "up_load", 0, 12'h000, 0, 1, 0);
    expect_at(s + 4, "up_1", 1, 12'h001, 0, 1, 1);
    expect_at(s + 8, "up_2", 2, 12'h002, 0, 1, 1);
    expect_at(s + 12, "up_3", 3, 12'h003, 0, 1, 1);
    expect_at(s + 40, "up_10", 10, 12'h010, 0, 1, 1);
    expect_at(s + 400, "up_100", 100, 12'h100, 0, 1, 1);
    expect_at(s + 3996, "up_999", 999, 12'h999, 0, 1, 1);
    expect_at(s + 3997, "up_999_hold", 999, 12'h999, 0, 1, 0);
    expect_at(s + 4000, "up_saturated", 999, 12'h999, 0, 1, 0);
    expect_at(s + 4004, "up_saturated2", 999, 12'h999, 0, 1, 0);
    run_to(s + 4005);
    // clamp on load, then restart from EXPIRED
    pulse(0, 1, 10'd1023, s);
    expect_at(s, "clamp", 999, 12'h999, 0, 1, 0);
    expect_at(s + 4, "clamp_dec", 998, 12'h998, 0, 1, 1);
    run_to(s + 4);
    pulse(0, 1, 10'd2, s);
    expect_at(s, "load2", 2, 12'h002, 0, 1, 0);
    expect_at(s + 4, "dec_1", 1, 12'h001, 0, 1, 1);
    expect_at(s + 8, "expire2", 0, 12'h000, 1, 0, 1);
    expect_at(s + 10, "expired_freeze_ignored", 0, 12'h000, 1, 0, 0);
    run_to(s + 8);
    freeze = 1'b1;
    run_to(s + 10);
    freeze = 1'b0;
    pulse(0, 1, 10'd2, s);
    expect_at(s, "restart_from_expired", 2, 12'h002, 0, 1, 0);
    expect_at(s + 4, "restart_dec", 1, 12'h001, 0, 1, 1);
    run_to(s + 5);
    // reset beats start mid-countdown
    rst = 1'b1; start = 1'b1; timer_seconds = 10'd7;
    step();
    s = cyc;
    rst = 1'b0; start = 1'b0;
    expect_at(s, "rst_over_start", 0, 12'h000, 0, 0, 0);
    expect_at(s + 4, "rst_no_residual", 0, 12'h000, 0, 0, 0);
    run_to(s + 4);
    // clear beats start
    pulse(0, 1, 10'd9, s);
    expect_at(s, "load9", 9, 12'h009, 0, 1, 0);
    run_to(s + 2);
    pulse(1, 1, 10'd9, s);
    expect_at(s, "clear_over_start", 0, 12'h000, 0, 0, 0);
    expect_at(s + 4, "clear_stays_idle", 0, 12'h000, 0, 0, 0);
    run_to(s + 5);
    step();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
